cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
// - Memory-side responder for the Cpu load/store/fetch request interface.
// - Services 8/16/32/48-bit reads and writes from a byte-wide internal RAM.
// - Accesses run byte-serially (big-endian).
// - Stalls the CPU through its enable input until the access completes.
// - Sits between Cpu and on-chip RAM; drives Cpu.enable and Cpu.data_in.
// PARAMETERS
// - ADDR_W      32  CPU address bus width
// - DEPTH_LOG2  12  log2 of RAM size in bytes; upper address bits ignored
// - DATA_MAX_W  48  widest transfer (48-bit instruction fetch)
// PORTS
// - clk          in   1           single clock, all logic on posedge
// - rst_n        in   1           synchronous reset, active-low
// - req_rd       in   1           read request (level)
// - req_wr       in   1           write request (level)
// - req_size     in   2           0=8b, 1=16b, 2=32b, 3=48b; N bytes = 1,2,4,6
// - req_addr     in   ADDR_W      byte address of most significant byte
// - req_wr_data  in   DATA_MAX_W  write data, right-justified, low 8*N bits used
// - cpu_enable   out  1           to Cpu.enable; 0 = CPU stalled
// - rd_data      out  DATA_MAX_W  to Cpu.data_in; right-justified, upper bits 0
// - err          out  1           1 in DONE cycle of a rejected request
// BEHAVIOUR
// - Reset (rst_n=0 at posedge):
//   - state=IDLE, rd_data=0, err=0, byte counter=0; RAM contents untouched.
//   - cpu_enable=0 while rst_n=0, holding the CPU stalled.
// - States: IDLE -> ACCESS -> DONE -> IDLE. REJECT path: IDLE -> DONE.
// - IDLE:
//   - cpu_enable = !(req_rd|req_wr), combinational, so the CPU stalls in the
//     same cycle its request appears.
//   - On req_rd^req_wr, latch size/addr/data and the op, clear counter k,
//     and go to ACCESS.
//   - On req_rd&req_wr, set err, do no access, and go to DONE.
// - ACCESS:
//   - cpu_enable=0.
//   - Byte k uses RAM address (addr+k) mod 2**DEPTH_LOG2; wrap is silent.
//   - Byte k maps to data bits [8*(N-k)-1 -: 8] (big-endian).
//   - Writes store one byte per cycle.
//   - Reads shift one byte per cycle into an accumulator; the 1-cycle
//     synchronous RAM latency is absorbed internally.
//   - After the last byte, go to DONE.
// - DONE (exactly 1 cycle):
//   - cpu_enable=1. rd_data is valid for reads; unchanged for writes or rejects.
//   - err=1 only for a rejected request, otherwise 0.
//   - Request inputs are ignored (they are the completed request).
//   - Next state is IDLE.
// - Latency: cpu_enable is low for exactly N+1 cycles, counted from the
//   cycle the request first appears in IDLE, then high in DONE.
//   - Rejected requests: low for exactly 1 cycle.
// - rd_data holds its value until the next read completes.
// - err returns to 0 in the cycle after DONE.
// - Protocol: the CPU holds req_* stable while stalled and drops or changes
//   them on the DONE edge. Any request level seen in IDLE is a new request.
// - Reset mid-access aborts at once:
//   - Bytes already written stay written; remaining bytes are untouched.
//   - A partial read is discarded.
// CONFIGURATION
// - CPU_MEM_RESP_ALIGN_CHECK_EN defined:
//   - A request whose addr is not a multiple of N (N=6: multiple of 2) is
//     rejected as a REJECT: no RAM access, 1-cycle stall, err=1 in DONE.
// - Undefined: every address is accepted; misaligned accesses run normally.
// TESTING
// - Write 32b 0xDEADBEEF @0x10, then read 8b @0x11:
//   - Write stalls 5 cycles.
//   - Read: rd_data=0x0000000000AD, cpu_enable low 2 cycles.
// - Preload bytes 01..06 @0x20, 48b read @0x20:
//   - rd_data=0x010203040506, cpu_enable low 7 cycles, err=0.
// - Wrap: 16b write 0xA55A @(2**DEPTH_LOG2-1):
//   - Byte 0xFFF=0xA5, byte 0x000=0x5A.
//   - 16b read @0xFFF returns 0x00000000A55A.
// - req_rd=req_wr=1 @0x40:
//   - 1-cycle stall, err=1 in DONE, RAM @0x40 unchanged, rd_data unchanged.
// - rst_n=0 after 2 bytes of a 32b write 0x11223344 @0x50:
//   - 0x50=0x11, 0x51=0x22, 0x52/0x53 unchanged.
//   - cpu_enable=0 during reset; IDLE afterwards.
// - 32b read @0x12:
//   - ALIGN_CHECK_EN: err=1, 1-cycle stall.
//   - Without: normal 5-cycle stall, err=0.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Byte-serial, big-endian memory responder that stalls the CPU through cpu_enable.
// Optional: define CPU_MEM_RESP_ALIGN_CHECK_EN to reject requests not aligned to their size.
module cpu_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_MAX_W = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [1:0]            req_size,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_MAX_W-1:0] req_wr_data,
  output logic                  cpu_enable,
  output logic [DATA_MAX_W-1:0] rd_data,
  output logic                  err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    is_rd_q, is_rd_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              k_q, k_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_MAX_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_MAX_W-1:0]   acc_q, acc_d;
  logic [DATA_MAX_W-1:0]   rd_data_q, rd_data_d;
  logic                    err_q, err_d;

  logic [7:0]              ram [2**DEPTH_LOG2];
  logic [7:0]              ram_rdata_q;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [7:0]              ram_wdata;

  logic                    req_any;
  logic                    reject;
  logic                    last_byte;
  logic [2:0]              req_n;
  logic [5:0]              byte_shift;
  logic [DATA_MAX_W-1:0]   acc_shifted;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2];

  assign req_any     = req_rd | req_wr;
  assign last_byte   = (k_q == n_q - 3'd1);
  assign byte_shift  = {n_q - k_q - 3'd1, 3'b000};
  assign acc_shifted = {acc_q[DATA_MAX_W-9:0], ram_rdata_q};

  always_comb begin
    case (req_size)
      2'd0:    req_n = 3'd1;
      2'd1:    req_n = 3'd2;
      2'd2:    req_n = 3'd4;
      default: req_n = 3'd6;
    endcase
  end

`ifdef CPU_MEM_RESP_ALIGN_CHECK_EN
  logic misaligned;

  // 48-bit fetches only need halfword alignment.
  always_comb begin
    case (req_size)
      2'd1, 2'd3: misaligned = req_addr[0];
      2'd2:       misaligned = |req_addr[1:0];
      default:    misaligned = 1'b0;
    endcase
  end

  assign reject = (req_rd & req_wr) | misaligned;
`else
  assign reject = req_rd & req_wr;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_any) state_d = reject ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (last_byte) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // In IDLE the RAM is pointed at the first byte so a read's latency hides behind the IDLE cycle.
  always_comb begin
    cpu_enable = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q + DEPTH_LOG2'(k_q);
    ram_wdata  = 8'(wr_data_q >> byte_shift);
    case (state_q)
      ST_IDLE: begin
        cpu_enable = rst_n & ~req_any;
        ram_addr   = req_addr[DEPTH_LOG2-1:0];
      end
      ST_ACCESS: begin
        ram_we = rst_n & ~is_rd_q;
        if (is_rd_q) ram_addr = addr_q + DEPTH_LOG2'(k_q) + DEPTH_LOG2'(1);
      end
      ST_DONE:   cpu_enable = rst_n;
      default:   cpu_enable = 1'b0;
    endcase
  end

  always_comb begin
    is_rd_d   = is_rd_q;
    n_d       = n_q;
    k_d       = k_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    acc_d     = acc_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        err_d = req_any & reject;
        if (req_any && !reject) begin
          is_rd_d   = req_rd;
          n_d       = req_n;
          k_d       = 3'd0;
          addr_d    = req_addr[DEPTH_LOG2-1:0];
          wr_data_d = req_wr_data;
          acc_d     = '0;
        end
      end
      ST_ACCESS: begin
        k_d = k_q + 3'd1;
        if (is_rd_q) begin
          acc_d = acc_shifted;
          if (last_byte) rd_data_d = acc_shifted;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_rd_q   <= 1'b0;
      n_q       <= 3'd1;
      k_q       <= 3'd0;
      addr_q    <= '0;
      wr_data_q <= '0;
      acc_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      is_rd_q   <= is_rd_d;
      n_q       <= n_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      acc_q     <= acc_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata_q <= ram[ram_addr];
  end

  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: directed scenarios plus random traffic against a byte-array model.
// Honours CPU_MEM_RESP_ALIGN_CHECK_EN when computing expected rejects.
module tb_cpu_mem_responder;

`ifdef CPU_MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef struct packed {
    bit          rd;
    bit          wr;
    logic [1:0]  s;
    logic [31:0] a;
    logic [47:0] d;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic        req_rd;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [47:0] req_wr_data;
  logic        cpu_enable;
  logic [47:0] rd_data;
  logic        err;

  int          n_checks;
  int          n_pass;
  logic [7:0]  model_mem [4096];
  logic [47:0] exp_rd_data;

  cpu_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wr_data(req_wr_data),
    .cpu_enable (cpu_enable),
    .rd_data    (rd_data),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 6;
    endcase
  endfunction

  function automatic bit model_reject(input bit rd, input bit wr, input logic [1:0] s,
                                      input logic [31:0] a);
    int n;
    int align;
    n = n_of(s);
    align = (n == 6) ? 2 : n;
    if (rd && wr) return 1'b1;
    if (ALIGN_EN && ((a % align) != 0)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: stall length, error flag and read value straight from the memory-image rules.
  task automatic model_txn(input txn_t t, output int exp_low, output logic exp_err,
                           output logic [47:0] exp_rd);
    int n;
    logic [47:0] v;
    n = n_of(t.s);
    if (model_reject(t.rd, t.wr, t.s, t.a)) begin
      exp_low = 1;
      exp_err = 1'b1;
    end else begin
      exp_low = n + 1;
      exp_err = 1'b0;
      if (t.rd) begin
        v = '0;
        for (int k = 0; k < n; k++) v = (v << 8) | 48'(model_mem[(t.a + k) % 4096]);
        exp_rd_data = v;
      end else begin
        for (int k = 0; k < n; k++) model_mem[(t.a + k) % 4096] = 8'(t.d >> (8 * (n - 1 - k)));
      end
    end
    exp_rd = exp_rd_data;
  endtask

  // Drives one request from IDLE, counts stalled cycles, captures outputs in the enable cycle.
  task automatic do_txn(input txn_t t, output int low, output logic [47:0] rdata,
                        output logic errv);
    bit got;
    req_rd      = t.rd;
    req_wr      = t.wr;
    req_size    = t.s;
    req_addr    = t.a;
    req_wr_data = t.d;
    low   = 0;
    got   = 1'b0;
    rdata = '0;
    errv  = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (cpu_enable === 1'b1) begin
        got   = 1'b1;
        rdata = rd_data;
        errv  = err;
      end else begin
        low++;
      end
    end
    @(posedge clk);
    #1;
    req_rd = 1'b0;
    req_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_rd      = 1'b0;
    req_wr      = 1'b0;
    req_size    = 2'd0;
    req_addr    = '0;
    req_wr_data = '0;
    exp_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cpu_enable !== 1'b0) $display("[TB] FAIL reset_stall: cpu_enable=%b want 0", cpu_enable);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_enable !== 1'b1) $display("[TB] FAIL reset_idle_en: cpu_enable=%b want 1", cpu_enable);
    else n_pass++;
    n_checks++;
    if (rd_data !== 48'h0) $display("[TB] FAIL reset_rd_data: got %h want 0", rd_data);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", err);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_examples();
    txn_t tbl[$];
    int low, exp_low;
    logic [47:0] rdata, exp_rd;
    logic errv, exp_err;
    tbl.push_back('{1'b0, 1'b1, 2'd2, 32'h0000_0010, 48'h0000_DEAD_BEEF});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 32'h0000_0014, 48'h0000_CAFE_F00D});
    tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h0000_0011, 48'h0});
    for (int i = 0; i < 6; i++)
      tbl.push_back('{1'b0, 1'b1, 2'd0, 32'h20 + 32'(i), 48'(i + 1)});
    tbl.push_back('{1'b1, 1'b0, 2'd3, 32'h0000_0020, 48'h0});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 32'h0000_0FFF, 48'h33});
    tbl.push_back('{1'b0, 1'b1, 2'd0, 32'h0000_0000, 48'h44});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h0000_0FFF, 48'hA55A});
    tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h0000_0FFF, 48'h0});
    tbl.push_back('{1'b1, 1'b0, 2'd0, 32'h0000_0000, 48'h0});
    tbl.push_back('{1'b1, 1'b0, 2'd1, 32'h0000_0FFF, 48'h0});
    tbl.push_back('{1'b1, 1'b0, 2'd2, 32'h0000_0012, 48'h0});
    foreach (tbl[i]) begin
      model_txn(tbl[i], exp_low, exp_err, exp_rd);
      do_txn(tbl[i], low, rdata, errv);
      n_checks++;
      if (low !== exp_low) $display("[TB] FAIL ex%0d_stall: got %0d want %0d", i, low, exp_low);
      else n_pass++;
      n_checks++;
      if (errv !== exp_err) $display("[TB] FAIL ex%0d_err: got %b want %b", i, errv, exp_err);
      else n_pass++;
      n_checks++;
      if (rdata !== exp_rd) $display("[TB] FAIL ex%0d_rd_data: got %h want %h", i, rdata, exp_rd);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (low !== 5) $display("[TB] FAIL wr32_stall: got %0d want 5", low);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (rdata !== 48'h0000_0000_00AD) $display("[TB] FAIL rd8_value: got %h want 0000000000ad", rdata);
        else n_pass++;
      end
      if (i == 9) begin
        n_checks++;
        if (rdata !== 48'h0102_0304_0506 || low !== 7)
          $display("[TB] FAIL rd48: got %h/%0d want 010203040506/7", rdata, low);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reject();
    int low, exp_low;
    logic [47:0] rdata, exp_rd, held;
    logic errv, exp_err;
    txn_t t;
    t = '{1'b0, 1'b1, 2'd0, 32'h40, 48'h77};
    model_txn(t, exp_low, exp_err, exp_rd);
    do_txn(t, low, rdata, errv);
    held = exp_rd_data;
    t = '{1'b1, 1'b1, 2'd0, 32'h40, 48'hEE};
    model_txn(t, exp_low, exp_err, exp_rd);
    do_txn(t, low, rdata, errv);
    n_checks++;
    if (low !== 1) $display("[TB] FAIL reject_stall: got %0d want 1", low);
    else n_pass++;
    n_checks++;
    if (errv !== 1'b1) $display("[TB] FAIL reject_err: got %b want 1", errv);
    else n_pass++;
    n_checks++;
    if (rdata !== held) $display("[TB] FAIL reject_rd_data: got %h want %h", rdata, held);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || cpu_enable !== 1'b1)
      $display("[TB] FAIL reject_after: err=%b en=%b want 0/1", err, cpu_enable);
    else n_pass++;
    @(posedge clk);
    #1;
    t = '{1'b1, 1'b0, 2'd0, 32'h40, 48'h0};
    model_txn(t, exp_low, exp_err, exp_rd);
    do_txn(t, low, rdata, errv);
    n_checks++;
    if (rdata !== 48'h77) $display("[TB] FAIL reject_ram_kept: got %h want 77", rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int low, exp_low;
    logic [47:0] rdata, exp_rd;
    logic errv, exp_err;
    txn_t t;
    t = '{1'b0, 1'b1, 2'd2, 32'h50, 48'hAABB_CCDD};
    model_txn(t, exp_low, exp_err, exp_rd);
    do_txn(t, low, rdata, errv);
    req_wr      = 1'b1;
    req_size    = 2'd2;
    req_addr    = 32'h50;
    req_wr_data = 48'h1122_3344;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_enable !== 1'b0) $display("[TB] FAIL midreset_stall: cpu_enable=%b want 0", cpu_enable);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_mem[12'h50] = 8'h11;
    model_mem[12'h51] = 8'h22;
    exp_rd_data = '0;
    @(negedge clk);
    n_checks++;
    if (cpu_enable !== 1'b1 || rd_data !== 48'h0 || err !== 1'b0)
      $display("[TB] FAIL midreset_idle: en=%b rd=%h err=%b want 1/0/0", cpu_enable, rd_data, err);
    else n_pass++;
    @(posedge clk);
    #1;
    t = '{1'b1, 1'b0, 2'd2, 32'h50, 48'h0};
    model_txn(t, exp_low, exp_err, exp_rd);
    do_txn(t, low, rdata, errv);
    n_checks++;
    if (rdata !== 48'h1122_CCDD) $display("[TB] FAIL midreset_ram: got %h want 00001122ccdd", rdata);
    else n_pass++;
    n_checks++;
    if (low !== exp_low) $display("[TB] FAIL midreset_rd_stall: got %0d want %0d", low, exp_low);
    else n_pass++;
  endtask

  task automatic test_random();
    int low, exp_low, kind, off;
    logic [47:0] rdata, exp_rd;
    logic errv, exp_err;
    logic [31:0] r;
    txn_t t;
    for (int i = 0; i < 64; i++) begin
      t = '{1'b0, 1'b1, 2'd2, 32'h100 + 32'(4 * i), 48'($urandom)};
      model_txn(t, exp_low, exp_err, exp_rd);
      do_txn(t, low, rdata, errv);
    end
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      off  = $urandom_range(0, 249);
      r    = $urandom;
      t.rd = (kind == 0) || (kind >= 5);
      t.wr = (kind <= 4);
      t.s  = 2'($urandom_range(0, 3));
      t.a  = {r[31:12], 12'(32'h100 + off)};
      t.d  = {16'($urandom), 32'($urandom)};
      model_txn(t, exp_low, exp_err, exp_rd);
      do_txn(t, low, rdata, errv);
      n_checks++;
      if (low !== exp_low) $display("[TB] FAIL rnd%0d_stall: got %0d want %0d", i, low, exp_low);
      else n_pass++;
      n_checks++;
      if (errv !== exp_err) $display("[TB] FAIL rnd%0d_err: got %b want %b", i, errv, exp_err);
      else n_pass++;
      n_checks++;
      if (rdata !== exp_rd) $display("[TB] FAIL rnd%0d_rd_data: got %h want %h", i, rdata, exp_rd);
      else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_examples();
    test_reject();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
